// File: rtl/uart_rx_status.sv
// Receive-side LSR bits, FIFO error accounting, trigger/timeout interrupts and IIR ID.
// The 16550 character timeout is built only when UART_RX_TIMEOUT_EN is defined.

module uart_rx_status #(
   parameter int FIFO_DEPTH = 16,
   parameter int TO_CHARS   = 4,
   parameter int TO_W       = 10,
   localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             PCLK,
   input  logic             PRESETn,
   input  logic             enable,
   input  logic [7:0]       LCR,
   input  logic [1:0]       FCR_trig,
   input  logic             rx_fifo_clear,
   input  logic             IER_rda,
   input  logic             IER_rls,
   input  logic             push_rx_fifo,
   input  logic             rx_push_err,
   input  logic             rx_overrun,
   input  logic             pop_rx_fifo,
   input  logic             lsr_read,
   input  logic [10:0]      rx_fifo_out,
   input  logic [CNT_W-1:0] rx_fifo_count,
   input  logic             rx_fifo_empty,
   output logic             lsr_dr,
   output logic             lsr_oe,
   output logic             lsr_pe,
   output logic             lsr_fe,
   output logic             lsr_bi,
   output logic             lsr_fifo_err,
   output logic             irq_rls,
   output logic             irq_rda,
   output logic             irq_cti,
   output logic [3:0]       rx_iir_id
);

   logic             empty_dly_q, empty_dly_d;
   logic             pop_dly_q, pop_dly_d;
   logic             head_new;
   logic             lsr_dr_q, lsr_dr_d;
   logic             lsr_oe_q, lsr_oe_d;
   logic             lsr_pe_q, lsr_pe_d;
   logic             lsr_fe_q, lsr_fe_d;
   logic             lsr_bi_q, lsr_bi_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic             err_inc, err_dec;
   logic             lsr_fifo_err_q, lsr_fifo_err_d;
   logic [CNT_W-1:0] trig_lvl;
   logic             irq_rls_q, irq_rls_d;
   logic             irq_rda_q, irq_rda_d;
   logic             irq_cti_q, irq_cti_d;
   logic [3:0]       rx_iir_id_q, rx_iir_id_d;
   logic             cti_d;
   logic             unused_inputs;

   // A new head word appears when the FIFO leaves empty or after a pop exposes the next entry.
   always_comb begin
      empty_dly_d = rx_fifo_empty;
      pop_dly_d   = pop_rx_fifo;
      head_new    = ~rx_fifo_empty & (empty_dly_q | pop_dly_q);

      lsr_dr_d = ~rx_fifo_empty;
      lsr_oe_d = (push_rx_fifo & rx_overrun)  | (lsr_oe_q & ~lsr_read);
      lsr_pe_d = (head_new & rx_fifo_out[9])  | (lsr_pe_q & ~lsr_read);
      lsr_fe_d = (head_new & rx_fifo_out[8])  | (lsr_fe_q & ~lsr_read);
      lsr_bi_d = (head_new & rx_fifo_out[10]) | (lsr_bi_q & ~lsr_read);
   end

   // Error words currently held in the FIFO; a push into a full FIFO is dropped upstream.
   always_comb begin
      err_inc   = push_rx_fifo & rx_push_err & (rx_fifo_count != CNT_W'(FIFO_DEPTH));
      err_dec   = pop_rx_fifo & (|rx_fifo_out[10:8]);
      err_cnt_d = err_cnt_q;
      if (rx_fifo_clear) begin
         err_cnt_d = '0;
      end else if (err_inc && !err_dec && (err_cnt_q != CNT_W'(FIFO_DEPTH))) begin
         err_cnt_d = err_cnt_q + CNT_W'(1);
      end else if (err_dec && !err_inc && (err_cnt_q != '0)) begin
         err_cnt_d = err_cnt_q - CNT_W'(1);
      end
      lsr_fifo_err_d = (err_cnt_d != '0);
   end

   always_comb begin
      trig_lvl = CNT_W'(1);
      case (FCR_trig)
         2'b00:   trig_lvl = CNT_W'(1);
         2'b01:   trig_lvl = CNT_W'(4);
         2'b10:   trig_lvl = CNT_W'(8);
         default: trig_lvl = CNT_W'(14);
      endcase

      irq_rls_d = IER_rls & (lsr_oe_d | lsr_pe_d | lsr_fe_d | lsr_bi_d);
      irq_rda_d = IER_rda & (rx_fifo_count >= trig_lvl);
      irq_cti_d = IER_rda & cti_d;

      rx_iir_id_d = 4'b0001;
      if (irq_rls_d) begin
         rx_iir_id_d = 4'b0110;
      end else if (irq_rda_d) begin
         rx_iir_id_d = 4'b0100;
      end else if (irq_cti_d) begin
         rx_iir_id_d = 4'b1100;
      end
   end

`ifdef UART_RX_TIMEOUT_EN
   logic [3:0]      char_bits;
   logic [TO_W-1:0] threshold;
   logic            to_clr;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            cti_q;

   // Counter saturates at the threshold; using >= keeps it stuck rather than wrapping if LCR shrinks it.
   always_comb begin
      char_bits = 4'd1 + 4'd5 + {2'b00, LCR[1:0]} + {3'b000, LCR[3]} + (LCR[2] ? 4'd2 : 4'd1);
      threshold = TO_W'(TO_CHARS * 16 * int'(char_bits));
      to_clr    = push_rx_fifo | pop_rx_fifo | rx_fifo_empty | rx_fifo_clear;

      to_cnt_d = to_cnt_q;
      if (to_clr) begin
         to_cnt_d = '0;
      end else if (enable && (to_cnt_q < threshold)) begin
         to_cnt_d = to_cnt_q + TO_W'(1);
      end

      cti_d = cti_q;
      if (to_clr) begin
         cti_d = 1'b0;
      end else if (to_cnt_d >= threshold) begin
         cti_d = 1'b1;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         to_cnt_q <= '0;
         cti_q    <= 1'b0;
      end else begin
         to_cnt_q <= to_cnt_d;
         cti_q    <= cti_d;
      end
   end

   assign unused_inputs = ^{rx_fifo_out[7:0], LCR[7:4]};
`else
   localparam int unused_to_cfg = TO_CHARS + TO_W;

   assign cti_d         = 1'b0;
   assign unused_inputs = ^{rx_fifo_out[7:0], LCR, enable};
`endif

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         empty_dly_q    <= 1'b0;
         pop_dly_q      <= 1'b0;
         lsr_dr_q       <= 1'b0;
         lsr_oe_q       <= 1'b0;
         lsr_pe_q       <= 1'b0;
         lsr_fe_q       <= 1'b0;
         lsr_bi_q       <= 1'b0;
         err_cnt_q      <= '0;
         lsr_fifo_err_q <= 1'b0;
         irq_rls_q      <= 1'b0;
         irq_rda_q      <= 1'b0;
         irq_cti_q      <= 1'b0;
         rx_iir_id_q    <= 4'b0001;
      end else begin
         empty_dly_q    <= empty_dly_d;
         pop_dly_q      <= pop_dly_d;
         lsr_dr_q       <= lsr_dr_d;
         lsr_oe_q       <= lsr_oe_d;
         lsr_pe_q       <= lsr_pe_d;
         lsr_fe_q       <= lsr_fe_d;
         lsr_bi_q       <= lsr_bi_d;
         err_cnt_q      <= err_cnt_d;
         lsr_fifo_err_q <= lsr_fifo_err_d;
         irq_rls_q      <= irq_rls_d;
         irq_rda_q      <= irq_rda_d;
         irq_cti_q      <= irq_cti_d;
         rx_iir_id_q    <= rx_iir_id_d;
      end
   end

   assign lsr_dr       = lsr_dr_q;
   assign lsr_oe       = lsr_oe_q;
   assign lsr_pe       = lsr_pe_q;
   assign lsr_fe       = lsr_fe_q;
   assign lsr_bi       = lsr_bi_q;
   assign lsr_fifo_err = lsr_fifo_err_q;
   assign irq_rls      = irq_rls_q;
   assign irq_rda      = irq_rda_q;
   assign irq_cti      = irq_cti_q;
   assign rx_iir_id    = rx_iir_id_q;

endmodule

// File: tb/tb_uart_rx_status.sv
// Scoreboard bench for uart_rx_status: stimulus queues expected outputs due N clock edges later,
// a negedge monitor pops and compares them; a small FIFO model drives the FIFO status inputs.

module tb_uart_rx_status;

   localparam int FIFO_DEPTH = 16;
`ifdef UART_RX_TIMEOUT_EN
   localparam logic TO_EN = 1'b1;
`else
   localparam logic TO_EN = 1'b0;
`endif
   localparam logic [3:0] CTI_EXP = {3'b000, TO_EN};
   localparam logic [3:0] CTI_IIR = TO_EN ? 4'hC : 4'h1;

   localparam int S_DR = 0, S_OE = 1, S_PE = 2, S_FE = 3, S_BI = 4;
   localparam int S_FERR = 5, S_RLS = 6, S_RDA = 7, S_CTI = 8, S_IIR = 9;

   logic        PCLK, PRESETn, enable;
   logic [7:0]  LCR;
   logic [1:0]  FCR_trig;
   logic        rx_fifo_clear, IER_rda, IER_rls;
   logic        push_rx_fifo, rx_push_err, rx_overrun, pop_rx_fifo, lsr_read;
   logic [10:0] rx_fifo_out;
   logic [4:0]  rx_fifo_count;
   logic        rx_fifo_empty;
   logic        lsr_dr, lsr_oe, lsr_pe, lsr_fe, lsr_bi, lsr_fifo_err;
   logic        irq_rls, irq_rda, irq_cti;
   logic [3:0]  rx_iir_id;

   typedef struct {
      int         due;
      int         sig;
      logic [3:0] val;
      string      name;
   } exp_t;

   exp_t        exp_q[$];
   logic [10:0] fifo_m[$];
   int          cyc = 0;
   int          applied = 0;
   int          miscompares = 0;

   uart_rx_status dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .enable(enable), .LCR(LCR), .FCR_trig(FCR_trig),
      .rx_fifo_clear(rx_fifo_clear), .IER_rda(IER_rda), .IER_rls(IER_rls),
      .push_rx_fifo(push_rx_fifo), .rx_push_err(rx_push_err), .rx_overrun(rx_overrun),
      .pop_rx_fifo(pop_rx_fifo), .lsr_read(lsr_read), .rx_fifo_out(rx_fifo_out),
      .rx_fifo_count(rx_fifo_count), .rx_fifo_empty(rx_fifo_empty),
      .lsr_dr(lsr_dr), .lsr_oe(lsr_oe), .lsr_pe(lsr_pe), .lsr_fe(lsr_fe), .lsr_bi(lsr_bi),
      .lsr_fifo_err(lsr_fifo_err), .irq_rls(irq_rls), .irq_rda(irq_rda), .irq_cti(irq_cti),
      .rx_iir_id(rx_iir_id)
   );

   initial begin
      PCLK = 1'b0;
      forever #5 PCLK = ~PCLK;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [3:0] actual_of(input int sig);
      case (sig)
         S_DR:    return {3'b000, lsr_dr};
         S_OE:    return {3'b000, lsr_oe};
         S_PE:    return {3'b000, lsr_pe};
         S_FE:    return {3'b000, lsr_fe};
         S_BI:    return {3'b000, lsr_bi};
         S_FERR:  return {3'b000, lsr_fifo_err};
         S_RLS:   return {3'b000, irq_rls};
         S_RDA:   return {3'b000, irq_rda};
         S_CTI:   return {3'b000, irq_cti};
         default: return rx_iir_id;
      endcase
   endfunction

   function automatic void check_output(input exp_t e);
      logic [3:0] act;
      act = actual_of(e.sig);
      applied++;
      if (act !== e.val) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", e.name, act, e.val, cyc);
      end
   endfunction

   // Monitor: compare every expectation that has come due at this edge count.
   always @(negedge PCLK) begin : monitor
      int idx;
      idx = 0;
      while (idx < exp_q.size()) begin
         if (exp_q[idx].due == cyc) begin
            check_output(exp_q[idx]);
            exp_q.delete(idx);
         end else if (exp_q[idx].due < cyc) begin
            applied++;
            miscompares++;
            $display("[TB] FAIL %s: check skipped, due edge %0d now %0d", exp_q[idx].name,
                     exp_q[idx].due, cyc);
            exp_q.delete(idx);
         end else begin
            idx++;
         end
      end
   end

   task automatic expect_at(input int k, input int sig, input logic [3:0] val, input string name);
      exp_t e;
      e.due  = cyc + k;
      e.sig  = sig;
      e.val  = val;
      e.name = name;
      exp_q.push_back(e);
   endtask

   task automatic expect_reset(input int k, input string tag);
      expect_at(k, S_DR,   4'h0, {tag, "_dr"});
      expect_at(k, S_OE,   4'h0, {tag, "_oe"});
      expect_at(k, S_PE,   4'h0, {tag, "_pe"});
      expect_at(k, S_FE,   4'h0, {tag, "_fe"});
      expect_at(k, S_BI,   4'h0, {tag, "_bi"});
      expect_at(k, S_FERR, 4'h0, {tag, "_fifo_err"});
      expect_at(k, S_RLS,  4'h0, {tag, "_irq_rls"});
      expect_at(k, S_RDA,  4'h0, {tag, "_irq_rda"});
      expect_at(k, S_CTI,  4'h0, {tag, "_irq_cti"});
      expect_at(k, S_IIR,  4'h1, {tag, "_iir"});
   endtask

   task automatic update_fifo_ports();
      rx_fifo_count = 5'(fifo_m.size());
      rx_fifo_empty = (fifo_m.size() == 0);
      rx_fifo_out   = (fifo_m.size() != 0) ? fifo_m[0] : 11'h000;
   endtask

   // One clock edge with the given pulses; the FIFO model then updates like the real FIFO.
   task automatic apply_stimulus(input logic push, input logic [10:0] word, input logic ovr,
                                 input logic pop, input logic lrd, input logic clr,
                                 input logic en);
      push_rx_fifo  = push;
      rx_push_err   = push & (|word[10:8]);
      rx_overrun    = ovr;
      pop_rx_fifo   = pop;
      lsr_read      = lrd;
      rx_fifo_clear = clr;
      enable        = en;
      @(posedge PCLK);
      #1;
      cyc++;
      if (clr) begin
         fifo_m.delete();
      end else begin
         if (pop && fifo_m.size() != 0) void'(fifo_m.pop_front());
         if (push && fifo_m.size() < FIFO_DEPTH) fifo_m.push_back(word);
      end
      update_fifo_ports();
      push_rx_fifo  = 1'b0;
      rx_push_err   = 1'b0;
      rx_overrun    = 1'b0;
      pop_rx_fifo   = 1'b0;
      lsr_read      = 1'b0;
      rx_fifo_clear = 1'b0;
      enable        = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) apply_stimulus(1'b0, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic push_word(input logic [10:0] w, input logic ovr, input logic lrd);
      apply_stimulus(1'b1, w, ovr, 1'b0, lrd, 1'b0, 1'b0);
   endtask

   task automatic pop_word();
      apply_stimulus(1'b0, 11'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic lsr_rd();
      apply_stimulus(1'b0, 11'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic flush();
      apply_stimulus(1'b0, 11'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         apply_stimulus(1'b0, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         idle(1);
      end
   endtask

   initial begin
      PRESETn  = 1'b0;
      LCR      = 8'h03;
      FCR_trig = 2'b01;
      IER_rda  = 1'b1;
      IER_rls  = 1'b0;
      push_rx_fifo = 1'b0; rx_push_err = 1'b0; rx_overrun = 1'b0; pop_rx_fifo = 1'b0;
      lsr_read = 1'b0; rx_fifo_clear = 1'b0; enable = 1'b0;
      update_fifo_ports();
      @(posedge PCLK);
      #1;
      expect_reset(0, "por");
      idle(1);
      PRESETn = 1'b1;
      idle(2);

      // Trigger level 4
      push_word(11'h011, 1'b0, 1'b0);
      push_word(11'h022, 1'b0, 1'b0);
      push_word(11'h033, 1'b0, 1'b0);
      expect_at(1, S_RDA, 4'h0, "rda_3_words");
      expect_at(1, S_DR,  4'h1, "dr_nonempty");
      push_word(11'h044, 1'b0, 1'b0);
      expect_at(1, S_RDA, 4'h1, "rda_4_words");
      expect_at(1, S_IIR, 4'h4, "iir_rda");
      idle(1);
      expect_at(2, S_RDA, 4'h0, "rda_after_pop");
      expect_at(2, S_IIR, 4'h1, "iir_after_pop");
      pop_word();
      idle(1);
      pop_word();
      pop_word();
      expect_at(2, S_DR, 4'h0, "dr_drained");
      pop_word();
      idle(1);

      // Parity error word, simultaneous push/pop, sticky clear
      IER_rls = 1'b1;
      expect_at(1, S_FERR, 4'h1, "fifo_err_push");
      expect_at(1, S_PE,   4'h0, "pe_not_yet");
      expect_at(2, S_PE,   4'h1, "pe_head");
      expect_at(2, S_FE,   4'h0, "fe_clean");
      expect_at(2, S_BI,   4'h0, "bi_clean");
      expect_at(2, S_RLS,  4'h1, "irq_rls_pe");
      expect_at(2, S_IIR,  4'h6, "iir_rls");
      push_word(11'h2A5, 1'b0, 1'b0);
      idle(1);
      expect_at(1, S_PE,  4'h0, "pe_lsr_read");
      expect_at(1, S_RLS, 4'h0, "irq_rls_cleared");
      expect_at(1, S_IIR, 4'h1, "iir_none");
      lsr_rd();
      expect_at(1, S_FERR, 4'h1, "fifo_err_net_zero");
      expect_at(1, S_PE,   4'h0, "pe_before_next_head");
      expect_at(2, S_PE,   4'h1, "pe_next_head");
      apply_stimulus(1'b1, 11'h25A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(1);
      expect_at(1, S_FERR, 4'h0, "fifo_err_pop");
      expect_at(2, S_DR,   4'h0, "dr_after_err_pop");
      pop_word();
      idle(1);
      expect_at(1, S_PE,  4'h0, "pe_clear2");
      expect_at(1, S_IIR, 4'h1, "iir_none2");
      lsr_rd();

      // Break + framing word
      expect_at(1, S_FERR, 4'h1, "fifo_err_bi");
      expect_at(2, S_BI,   4'h1, "bi_head");
      expect_at(2, S_FE,   4'h1, "fe_head");
      expect_at(2, S_PE,   4'h0, "pe_clean");
      expect_at(2, S_IIR,  4'h6, "iir_rls_bi");
      push_word(11'h5C3, 1'b0, 1'b0);
      idle(1);
      expect_at(1, S_BI, 4'h0, "bi_cleared");
      expect_at(1, S_FE, 4'h0, "fe_cleared");
      lsr_rd();
      expect_at(1, S_FERR, 4'h0, "fifo_err_bi_pop");
      pop_word();
      idle(1);

      // Overrun coinciding with an LSR read: set wins
      expect_at(1, S_OE,  4'h1, "oe_set_wins");
      expect_at(1, S_RLS, 4'h1, "irq_rls_oe");
      expect_at(1, S_IIR, 4'h6, "iir_rls_oe");
      push_word(11'h07E, 1'b1, 1'b1);
      expect_at(1, S_OE,  4'h0, "oe_cleared");
      expect_at(1, S_RLS, 4'h0, "irq_rls_oe_clr");
      lsr_rd();
      pop_word();
      idle(1);

      // Fill to full with trigger level 14, then an errored push into a full FIFO
      IER_rls  = 1'b0;
      FCR_trig = 2'b11;
      for (int i = 0; i < 13; i++) push_word(11'(i + 1), 1'b0, 1'b0);
      expect_at(1, S_RDA, 4'h0, "rda_13_words");
      push_word(11'h0E0, 1'b0, 1'b0);
      expect_at(1, S_RDA, 4'h1, "rda_14_words");
      expect_at(1, S_IIR, 4'h4, "iir_rda_14");
      push_word(11'h0E1, 1'b0, 1'b0);
      push_word(11'h0E2, 1'b0, 1'b0);
      expect_at(1, S_FERR, 4'h0, "fifo_err_full_drop");
      expect_at(1, S_OE,   4'h1, "oe_full");
      push_word(11'h1FF, 1'b1, 1'b0);
      expect_at(1, S_FERR, 4'h0, "fifo_err_after_flush");
      expect_at(2, S_RDA,  4'h0, "rda_after_flush");
      expect_at(2, S_DR,   4'h0, "dr_after_flush");
      flush();
      idle(1);
      expect_at(1, S_OE, 4'h0, "oe_cleared_full");
      lsr_rd();

      // Character timeout: LCR=03 gives 4*10*16 = 640 ticks
      FCR_trig = 2'b01;
      push_word(11'h055, 1'b0, 1'b0);
      idle(2);
      ticks(639);
      expect_at(0, S_CTI, 4'h0, "cti_639_ticks");
      expect_at(0, S_IIR, 4'h1, "iir_639_ticks");
      expect_at(1, S_CTI, CTI_EXP, "cti_640_ticks");
      expect_at(1, S_IIR, CTI_IIR, "iir_cti");
      apply_stimulus(1'b0, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_at(5, S_CTI, CTI_EXP, "cti_held");
      idle(5);
      expect_at(1, S_CTI, 4'h0, "cti_pop");
      expect_at(1, S_IIR, 4'h1, "iir_after_cti_pop");
      expect_at(2, S_DR,  4'h0, "dr_after_cti_pop");
      pop_word();
      idle(1);

      // Flush with two error words and the timeout pending
      push_word(11'h2A5, 1'b0, 1'b0);
      push_word(11'h2B6, 1'b0, 1'b0);
      idle(2);
      expect_at(0, S_FERR, 4'h1, "fifo_err_two");
      expect_at(0, S_PE,   4'h1, "pe_two");
      ticks(640);
      expect_at(0, S_CTI,  CTI_EXP, "cti_before_flush");
      expect_at(1, S_FERR, 4'h0, "fifo_err_flush");
      expect_at(1, S_CTI,  4'h0, "cti_flush");
      expect_at(1, S_PE,   4'h1, "pe_kept_by_flush");
      flush();
      idle(1);
      expect_at(1, S_PE, 4'h0, "pe_clear3");
      lsr_rd();

      // Reset mid-operation with OE set and three error words queued
      push_word(11'h1AA, 1'b0, 1'b0);
      push_word(11'h1AA, 1'b0, 1'b0);
      push_word(11'h1AA, 1'b0, 1'b0);
      push_word(11'h033, 1'b1, 1'b0);
      expect_at(1, S_OE,   4'h1, "oe_before_reset");
      expect_at(1, S_FERR, 4'h1, "fifo_err_before_reset");
      idle(2);
      PRESETn = 1'b0;
      fifo_m.delete();
      update_fifo_ports();
      expect_reset(0, "async_rst");
      idle(2);
      PRESETn = 1'b1;
      idle(1);
      expect_at(1, S_FERR, 4'h1, "fifo_err_post_reset");
      push_word(11'h1AA, 1'b0, 1'b0);
      expect_at(1, S_FERR, 4'h0, "err_cnt_was_zeroed");
      pop_word();
      idle(2);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge PCLK);
      #1;
      while (exp_q.size() != 0) begin
         applied++;
         miscompares++;
         $display("[TB] FAIL %s: never checked, got none required due edge %0d",
                  exp_q[0].name, exp_q[0].due);
         void'(exp_q.pop_front());
      end
      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
